// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue_ctrl
// Purpose  : Issue controller sitting between an operation request stream and
//            four execution units (arithmetic, logic, compare, shift). It
//            accepts one operation at a time, registers the operands toward
//            the units, enables the selected unit, captures the unit's
//            OR-combined flag/result and presents it on a result handshake.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   CLK, RST            : clock (rising edge), synchronous active-high reset
//   IN_VALID/IN_READY   : request handshake (IN_READY high only when idle)
//   A_IN, B_IN, ALU_FUN : operands and 4-bit opcode ([3:2] unit, [1:0] func)
//   ARITH_EN, LOGIC_EN,
//   CMP_EN, SHIFT_EN    : one-hot unit enable while executing
//   ALU_FUN_UNIT, A_OUT,
//   B_OUT               : registered operation presented to the units
//   UNIT_FLAG,
//   UNIT_RESULT         : OR-combined completion flag/result from the units
//   RES_VALID/RES_READY : result handshake
//   RES_OUT, RES_ERR    : captured result and timeout error indication
// ----------------------------------------------------------------------------
// Build option
//   ALU_ISSUE_TIMEOUT_EN : when defined, an 8-bit execute-cycle counter ends
//                          an operation after TIMEOUT_CYCLES cycles without a
//                          flag (RES_OUT=0, RES_ERR=1). When undefined the
//                          controller waits indefinitely and RES_ERR is 0.
// ============================================================================
module alu_issue_ctrl #(
    parameter int A_width        = 16,
    parameter int B_width        = 16,
    parameter int OUT_width      = A_width,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IN_VALID,
    output logic                 IN_READY,
    input  logic [A_width-1:0]   A_IN,
    input  logic [B_width-1:0]   B_IN,
    input  logic [3:0]           ALU_FUN,
    output logic                 ARITH_EN,
    output logic                 LOGIC_EN,
    output logic                 CMP_EN,
    output logic                 SHIFT_EN,
    output logic [1:0]           ALU_FUN_UNIT,
    output logic [A_width-1:0]   A_OUT,
    output logic [B_width-1:0]   B_OUT,
    input  logic                 UNIT_FLAG,
    input  logic [OUT_width-1:0] UNIT_RESULT,
    output logic                 RES_VALID,
    input  logic                 RES_READY,
    output logic [OUT_width-1:0] RES_OUT,
    output logic                 RES_ERR
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   w_accept;
    logic                   w_capture;
    logic                   w_expire;
    logic                   w_exec_expired;

    logic [A_width-1:0]     r_a_out;
    logic [B_width-1:0]     r_b_out;
    logic [1:0]             r_fun_unit;
    logic [1:0]             r_unit_sel;
    logic                   r_first_exec;
    logic [OUT_width-1:0]   r_res_out;

    // Parameter sanity: the execute limit must fit the 8-bit counter and
    // leave at least one flag-eligible cycle after the first one.
    always_ff @(posedge CLK) begin
        if (RST) begin
            assert (TIMEOUT_CYCLES >= 2 && TIMEOUT_CYCLES <= 255)
                else $error("alu_issue_ctrl: TIMEOUT_CYCLES out of range");
        end
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_capture    = 1'b0;
        w_expire     = 1'b0;
        IN_READY     = 1'b0;
        RES_VALID    = 1'b0;
        ARITH_EN     = 1'b0;
        LOGIC_EN     = 1'b0;
        CMP_EN       = 1'b0;
        SHIFT_EN     = 1'b0;

        case (r_state)
            IDLE: begin
                IN_READY = 1'b1;
                if (IN_VALID) begin
                    w_accept     = 1'b1;
                    w_next_state = EXEC;
                end
            end

            EXEC: begin
                ARITH_EN = (r_unit_sel == 2'b00);
                LOGIC_EN = (r_unit_sel == 2'b01);
                CMP_EN   = (r_unit_sel == 2'b10);
                SHIFT_EN = (r_unit_sel == 2'b11);
                // The units register one cycle after their enable, so a flag
                // seen in the first execute cycle is stale from an earlier
                // operation. A flag always beats the timeout on the last cycle.
                if (!r_first_exec && UNIT_FLAG) begin
                    w_capture    = 1'b1;
                    w_next_state = DONE;
                end else if (w_exec_expired) begin
                    w_expire     = 1'b1;
                    w_next_state = DONE;
                end
            end

            DONE: begin
                RES_VALID = 1'b1;
                // Returning to IDLE here (not accepting) keeps one free cycle
                // between the consumed result and the next request.
                if (RES_READY) begin
                    w_next_state = IDLE;
                end
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Operation and result registers
    // ------------------------------------------------------------------
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_a_out      <= '0;
            r_b_out      <= '0;
            r_fun_unit   <= '0;
            r_unit_sel   <= '0;
            r_first_exec <= 1'b0;
            r_res_out    <= '0;
        end else begin
            if (w_accept) begin
                r_a_out      <= A_IN;
                r_b_out      <= B_IN;
                r_fun_unit   <= ALU_FUN[1:0];
                r_unit_sel   <= ALU_FUN[3:2];
                r_first_exec <= 1'b1;
            end else if (r_state == EXEC) begin
                r_first_exec <= 1'b0;
            end

            if (w_capture) begin
                r_res_out <= UNIT_RESULT;
            end else if (w_expire) begin
                r_res_out <= '0;
            end
        end
    end

`ifdef ALU_ISSUE_TIMEOUT_EN
    // Count value on the last allowed execute cycle: the counter is 0 during
    // the first execute cycle, so the limit is reached at TIMEOUT_CYCLES-1.
    localparam logic [7:0] C_TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_exec_cnt;
    logic       r_res_err;

    assign w_exec_expired = (r_exec_cnt == C_TIMEOUT_LAST);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_exec_cnt <= '0;
        end else if (w_accept) begin
            r_exec_cnt <= '0;
        end else if (r_state == EXEC) begin
            r_exec_cnt <= r_exec_cnt + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_res_err <= 1'b0;
        end else if (w_capture) begin
            r_res_err <= 1'b0;
        end else if (w_expire) begin
            r_res_err <= 1'b1;
        end
    end

    assign RES_ERR = r_res_err;
`else
    assign w_exec_expired = 1'b0;
    assign RES_ERR        = 1'b0;
`endif

    assign A_OUT        = r_a_out;
    assign B_OUT        = r_b_out;
    assign ALU_FUN_UNIT = r_fun_unit;
    assign RES_OUT      = r_res_out;

endmodule
`default_nettype wire
